three_phase_spwm: RTL

Three-phase sinusoidal PWM modulator, the consumer end of the three-phase sine generator bus. Takes three 12-bit sign-magnitude reference samples (bit 11 = negative half-cycle flag, bits 10:0 = magnitude), converts them to offset binary, and compares them against a shared up/down triangle carrier. Produces complementary high-side/low-side gate drives per phase with programmable dead time for the inverter bridge, plus a carrier-valley sync pulse.

---
 rtl/three_phase_spwm.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/three_phase_spwm.sv
// Three-phase sinusoidal PWM modulator: sign-magnitude references sampled at the
// carrier valley, compared against an up/down triangle, then dead-time inserted per phase.

module spwm_phase #(
  parameter int DEAD = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        act,
  input  logic        sample,
  input  logic [11:0] ref_in,
  input  logic [11:0] cnt,
  output logic        gate_hi,
  output logic        gate_lo
);
  localparam logic [9:0] DEAD_V = 10'(DEAD);

  logic [11:0] conv, lvl_q, lvl_d;
  logic        cmp_q, cmp_d, state_q, state_d, hi_q, hi_d, lo_q, lo_d;
  logic [9:0]  dt_q, dt_d;

  // 2048 + 2047 tops out at exactly 4095, so the positive half never needs clamping
  always_comb begin
    if (ref_in[11]) conv = 12'd2048 - {1'b0, ref_in[10:0]};
    else            conv = 12'd2048 + {1'b0, ref_in[10:0]};
  end

  always_comb begin
    lvl_d   = (act && sample) ? conv : lvl_q;
    cmp_d   = act && (lvl_q > cnt);
    state_d = state_q;
    dt_d    = dt_q;
    if (!act) begin
      state_d = 1'b0;
      dt_d    = DEAD_V;
    end else if (cmp_q != state_q) begin
      state_d = cmp_q;
      dt_d    = DEAD_V;
    end else if (dt_q != 10'd0) begin
      dt_d = dt_q - 10'd1;
    end
    // gates follow the post-update state so DEAD = 0 switches both on one edge
    hi_d = act && (dt_d == 10'd0) && state_d;
    lo_d = act && (dt_d == 10'd0) && !state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_q   <= 12'd2048;
      cmp_q   <= 1'b0;
      state_q <= 1'b0;
      dt_q    <= DEAD_V;
      hi_q    <= 1'b0;
      lo_q    <= 1'b0;
    end else begin
      lvl_q   <= lvl_d;
      cmp_q   <= cmp_d;
      state_q <= state_d;
      dt_q    <= dt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign gate_hi = hi_q;
  assign gate_lo = lo_q;
endmodule

module three_phase_spwm #(
  parameter int PRESCALE = 1,
  parameter int DEAD     = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] ref_a,
  input  logic [11:0] ref_b,
  input  logic [11:0] ref_c,
  output logic [2:0]  gate_hi,
  output logic [2:0]  gate_lo,
  output logic        sync_valley
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]   presc_q, presc_d;
  logic [11:0]     cnt_q, cnt_d;
  logic            dir_q, dir_d;  // 0 = counting up
  logic            tick, valley, act;
  logic [2:0][11:0] refs;

  assign refs        = {ref_c, ref_b, ref_a};
  assign act         = en && !rst;
  assign tick        = (presc_q == PW'(PRESCALE - 1));
  assign valley      = tick && (cnt_q == 12'd0);
  assign sync_valley = act && valley;

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (!en) begin
      presc_d = '0;
      cnt_d   = 12'd0;
      dir_d   = 1'b0;
    end else if (tick) begin
      presc_d = '0;
      if (!dir_q) begin
        if (cnt_q == 12'hFFF) begin
          cnt_d = 12'hFFE;
          dir_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end else if (cnt_q == 12'd0) begin
        cnt_d = 12'd1;
        dir_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 12'd1;
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= 12'd0;
      dir_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  for (genvar p = 0; p < 3; p++) begin : g_ph
    spwm_phase #(.DEAD(DEAD)) u_ph (
      .clk    (clk),
      .rst    (rst),
      .act    (act),
      .sample (valley),
      .ref_in (refs[p]),
      .cnt    (cnt_q),
      .gate_hi(gate_hi[p]),
      .gate_lo(gate_lo[p])
    );
  end
endmodule
